// File: rtl/lockstep_pkg.sv
// rtl/lockstep_pkg.sv - shared types and default constants for the lockstep checker
package lockstep_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    CHECK = 2'd2,
    FAULT = 2'd3
  } state_t;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_DELAY  = 2;
  localparam int DEF_THRESH = 3;
  localparam int DEF_CNT_W  = 16;

  // DELAY and THRESH are both capped at 15, so 4-bit counters cover them
  localparam int FILL_W   = 4;
  localparam int CONSEC_W = 4;

endpackage

// File: rtl/delay_line.sv
// rtl/delay_line.sv - fixed-length shift register aligning the primary bus to the shadow core
module delay_line
  import lockstep_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DELAY = DEF_DELAY
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (DELAY == 0) begin : g_bypass
      assign q = d;
    end else begin : g_shift
      logic [WIDTH-1:0] sr [DELAY];

      // Shift every cycle unconditionally; stage DELAY-1 holds data from DELAY edges ago
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < DELAY; i++) begin
            sr[i] <= '0;
          end
        end else begin
          sr[0] <= d;
          for (int i = 1; i < DELAY; i++) begin
            sr[i] <= sr[i-1];
          end
        end
      end

      assign q = sr[DELAY-1];
    end
  endgenerate

endmodule

// File: rtl/lockstep_checker.sv
// rtl/lockstep_checker.sv - time-diverse lockstep comparator with error counter and sticky fault
module lockstep_checker
  import lockstep_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DELAY  = DEF_DELAY,
  parameter int THRESH = DEF_THRESH,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  input  logic             fault_ack,
  output logic             mismatch,
  output logic             fault,
  output logic [CNT_W-1:0] err_count,
  output logic [1:0]       state
);

  // Where to go when checking (re)starts: skip FILL entirely when there is no lag
  localparam state_t              ENTRY_STATE = (DELAY == 0) ? CHECK : FILL;
  localparam logic [FILL_W-1:0]   FILL_LAST   = FILL_W'((DELAY > 0) ? DELAY - 1 : 0);
  localparam logic [CONSEC_W-1:0] THRESH_C    = CONSEC_W'(THRESH);
  localparam logic [CNT_W-1:0]    CNT_MAX     = {CNT_W{1'b1}};

  state_t              cur_state, nxt_state;
  logic [FILL_W-1:0]   fill_cnt, fill_nxt;
  logic [CONSEC_W-1:0] consec, consec_nxt;
  logic [CNT_W-1:0]    err_nxt;
  logic                mismatch_nxt;
  logic                fault_nxt;
  logic [WIDTH-1:0]    a_dly;
  logic                diff;

  delay_line #(
    .WIDTH (WIDTH),
    .DELAY (DELAY)
  ) u_delay_line (
    .clk   (clk),
    .reset (reset),
    .d     (data_a),
    .q     (a_dly)
  );

  assign diff  = (a_dly != data_b);
  assign state = cur_state;

  // Next-state, counter and flag decisions for the current cycle
  always_comb begin
    nxt_state    = cur_state;
    fill_nxt     = fill_cnt;
    consec_nxt   = consec;
    err_nxt      = err_count;
    mismatch_nxt = 1'b0;
    fault_nxt    = fault;

    case (cur_state)
      IDLE: begin
        if (enable) begin
          nxt_state = ENTRY_STATE;
          fill_nxt  = '0;
        end
      end

      FILL: begin
        if (!enable) begin
          nxt_state = IDLE;
          fill_nxt  = '0;
        end else if (fill_cnt == FILL_LAST) begin
          nxt_state = CHECK;
          fill_nxt  = '0;
        end else begin
          fill_nxt = fill_cnt + 1'b1;
        end
      end

      CHECK: begin
        if (!enable) begin
          nxt_state  = IDLE;
          consec_nxt = '0;
        end else if (diff) begin
          mismatch_nxt = 1'b1;
          err_nxt      = (err_count == CNT_MAX) ? err_count : err_count + 1'b1;
          consec_nxt   = consec + 1'b1;
          if ((consec + 1'b1) == THRESH_C) begin
            nxt_state = FAULT;
            fault_nxt = 1'b1;
          end
        end else begin
          consec_nxt = '0;
        end
      end

      FAULT: begin
        // Comparisons and the error count stay frozen until software acknowledges
        if (fault_ack) begin
          fault_nxt  = 1'b0;
          consec_nxt = '0;
          fill_nxt   = '0;
          nxt_state  = enable ? ENTRY_STATE : IDLE;
        end
      end

      default: begin
        nxt_state = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset wins immediately, discarding any pending pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_state <= IDLE;
      fill_cnt  <= '0;
      consec    <= '0;
      err_count <= '0;
      mismatch  <= 1'b0;
      fault     <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      fill_cnt  <= fill_nxt;
      consec    <= consec_nxt;
      err_count <= err_nxt;
      mismatch  <= mismatch_nxt;
      fault     <= fault_nxt;
    end
  end

endmodule

// File: doc/lockstep_checker.md
# lockstep_checker

Downstream consumer of the glitch injector: compares the primary core's (possibly glitched) output bus against the shadow core's bus in a time-diverse lockstep pair and flags divergence. The shadow core runs DELAY cycles behind, so the primary stream is delayed internally before comparison. Raises a per-cycle mismatch pulse, counts errors, and latches a sticky fault after THRESH consecutive mismatches until software acknowledges it.

## Interface
- WIDTH, 8: data bus width of both cores.
- DELAY, 2: shadow-core lag in cycles, legal range 0..15.
- THRESH, 3: consecutive mismatches required to raise fault, legal range 1..15.
- CNT_W, 16: width of the saturating error counter.

- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  checking enabled; low returns FSM to IDLE (except from FAULT).
- data_a  input  WIDTH  primary-core bus (output of the glitch injector).
- data_b  input  WIDTH  shadow-core bus, DELAY cycles behind data_a.
- fault_ack  input  1  clears the sticky fault; sampled only in FAULT.
- mismatch  output  1  registered one-cycle pulse per miscompare.
- fault  output  1  sticky fault flag.
- err_count  output  CNT_W  saturating total miscompare count.
- state  output  2  current FSM state encoding.

## Operation
- Delay line: shifts data_a every cycle regardless of enable or state; a_dly equals data_a sampled DELAY edges earlier. DELAY=0: a_dly = data_a directly.
- FSM states: IDLE=0, FILL=1, CHECK=2, FAULT=3.
- IDLE: enable=1 -> FILL (DELAY>0) or CHECK (DELAY=0). Fill counter loaded to 0.
- FILL: count DELAY edges with enable=1, then -> CHECK. No comparisons. enable=0 -> IDLE.
- CHECK: each edge compare a_dly vs data_b. Unequal: mismatch=1, err_count+1 (saturate at all-ones), consec+1. Equal: consec cleared. consec reaching THRESH -> FAULT on that same edge. enable=0 -> IDLE, consec cleared; no comparison that edge.
- FAULT: fault=1, no comparisons, err_count frozen. enable ignored. fault_ack=1 -> fault cleared, consec cleared, -> FILL if enable=1 (CHECK if DELAY=0), else IDLE.
- fault_ack outside FAULT has no effect.
- err_count never clears except by reset; persists across fault_ack and enable toggling.
- Differences in any bit, including a single flipped bit, count as a mismatch.

## Timing
- Reset (asynchronous assert): mismatch=0, fault=0, err_count=0, state=IDLE, consec=0, fill counter=0, delay line all zeros. Release synchronous to next edge.
- Compare at edge k uses data_b at k and data_a from edge k-DELAY; mismatch, err_count, consec, fault all update at edge k, visible in cycle k+1.
- mismatch high for exactly one cycle per miscompare; back-to-back miscompares give continuous high.
- Entering CHECK from IDLE: first comparison on the (DELAY+1)-th edge after the edge sampling enable=1.
- THRESH-th consecutive miscompare: mismatch and fault both rise at the same edge; state reads FAULT from that cycle.
- fault_ack at edge k: fault low from cycle k+1.
- Reset mid-operation (any state): immediate return to reset values, no pending pulse.

## Structure
- Shared package lockstep_pkg: state enum (IDLE, FILL, CHECK, FAULT) with 2-bit encoding, default parameter constants.
- Sub-module delay_line (parameters WIDTH, DELAY; ports clk, reset, d, q): shift register with DELAY=0 bypass. Rest (FSM, counters, compare) in lockstep_checker.

## Test plan
- Reset: reset=1 for 2 cycles with random inputs -> mismatch=0, fault=0, err_count=0, state=0.
- Clean stream (DELAY=2, THRESH=3): data_a=0xAA, data_b=0xAA constant, enable=1 -> state 1 for 2 cycles then 2; 100 cycles, mismatch never high, err_count=0.
- Single glitch: in CHECK, data_b=0xAB for one cycle -> mismatch high exactly one cycle, err_count=1, fault=0, state stays 2.
- Fault path: data_b=0x55 for 3 cycles -> mismatch 3 cycles, fault rises with third, err_count=3, state=3; data restored, enable dropped: fault stays 1; fault_ack pulse with enable=1 -> fault=0, state 1 then 2 after 2 edges, err_count still 3.
- Non-consecutive: 2 mismatches, 1 match, 2 mismatches -> no fault, err_count=4.
- Saturation and reset mid-FAULT: CNT_W=4, THRESH=15, continuous mismatches -> err_count sticks at 15; then reset asserted while in FAULT -> all outputs zero immediately, state=0.
